// File: rtl/multicycle_control_unit.sv
// Multicycle control sequencer: owns the control state register and drives
// every datapath strobe and mux select from the registered state.
// Handles the memory ready/wait handshake, a bounded memory timeout, and
// sticky HALT/ERROR terminal states.
// Ports: clk, reset (sync, active-high), opcode[5:0], mem_ready -> state[3:0],
//   1-bit strobes (pcWrite, pcWriteCond, memGetData, memRead, irWrite,
//   regWrite, aluSrcA, regTrackSelect), 2-bit selects (regWriteDataSelect,
//   aluSrcB, pcSrc), aluOP[ALUOP_W-1:0], halted, error, err_cause[1:0].
// Optional macro MCU_PERF_COUNT_EN adds instr_retired[31:0] and
//   stall_cycles[31:0] (saturating, frozen in HALT/ERROR).
module multicycle_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [3:0]         state,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               memGetData,
    output logic               memRead,
    output logic               irWrite,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic               regTrackSelect,
    output logic [1:0]         regWriteDataSelect,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         pcSrc,
    output logic [ALUOP_W-1:0] aluOP,
    output logic               halted,
    output logic               error,
    output logic [1:0]         err_cause
`ifdef MCU_PERF_COUNT_EN
    ,
    output logic [31:0]        instr_retired,
    output logic [31:0]        stall_cycles
`endif
);

    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_RF      = 4'd1;
    localparam logic [3:0] S_IMM2    = 4'd2;
    localparam logic [3:0] S_ALU_R3  = 4'd3;
    localparam logic [3:0] S_ALU_RI3 = 4'd4;
    localparam logic [3:0] S_ALU4    = 4'd5;
    localparam logic [3:0] S_BR3     = 4'd6;
    localparam logic [3:0] S_MEM3    = 4'd7;
    localparam logic [3:0] S_LD4     = 4'd8;
    localparam logic [3:0] S_ST4     = 4'd9;
    localparam logic [3:0] S_LD5     = 4'd10;
    localparam logic [3:0] S_J3      = 4'd11;
    localparam logic [3:0] S_HALT    = 4'd12;
    localparam logic [3:0] S_ERROR   = 4'd13;

    localparam logic [3:0] ALU_ADD = 4'd0;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // Last waiting count before the timeout fires; unused when MEM_TIMEOUT=0.
    localparam bit            TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [3:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            halted_q, halted_d;
    logic            error_q, error_d;
    logic [1:0]      cause_q, cause_d;
    logic            is_mem;
    logic [3:0]      aluop4;

    assign is_mem = (state_q == S_IF) || (state_q == S_LD4) ||
                    (state_q == S_ST4);

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        halted_d = halted_q;
        error_d  = error_q;
        cause_d  = cause_q;

        case (state_q)
            S_IF: state_d = S_RF;
            S_RF: begin
                unique case (1'b1)
                    opcode[5:4] == 2'b00:  state_d = S_ALU_R3;
                    opcode[5:4] == 2'b01:  state_d = S_ALU_RI3;
                    opcode[5:3] == 3'b100: state_d = S_BR3;
                    opcode[5:3] == 3'b101: state_d = S_MEM3;
                    opcode == 6'b110000:   state_d = S_J3;
                    opcode == 6'b110001:   state_d = S_IMM2;
                    opcode == 6'b111111:   state_d = S_HALT;
                    default: begin
                        state_d = S_ERROR;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_IMM2:    state_d = S_IF;
            S_ALU_R3:  state_d = S_ALU4;
            S_ALU_RI3: state_d = S_ALU4;
            S_ALU4:    state_d = S_IF;
            S_BR3:     state_d = S_IF;
            S_MEM3:    state_d = opcode[2] ? S_ST4 : S_LD4;
            S_LD4:     state_d = S_LD5;
            S_ST4:     state_d = S_IF;
            S_LD5:     state_d = S_IF;
            S_J3:      state_d = S_IF;
            S_HALT:    state_d = S_HALT;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_IF;
        endcase

        // Memory states only advance on mem_ready; a ready in the final
        // counted cycle still wins over the timeout.
        if (is_mem && !mem_ready) begin
            if (TO_EN && (to_cnt_q == TO_LAST)) begin
                state_d = S_ERROR;
                cause_d = CAUSE_TIMEOUT;
            end else begin
                state_d  = state_q;
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (state_d == S_HALT)  halted_d = 1'b1;
        if (state_d == S_ERROR) error_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IF;
            to_cnt_q <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        pcWrite            = 1'b0;
        pcWriteCond        = 1'b0;
        memGetData         = 1'b0;
        memRead            = 1'b1;
        irWrite            = 1'b0;
        regWrite           = 1'b0;
        aluSrcA            = 1'b0;
        regWriteDataSelect = 2'd0;
        aluSrcB            = 2'd0;
        pcSrc              = 2'd0;
        aluop4             = ALU_ADD;

        case (state_q)
            S_IF: begin
                memGetData = 1'b1;
                irWrite    = mem_ready;
                pcWrite    = mem_ready;
                pcSrc      = 2'd2;
            end
            S_RF: aluSrcB = 2'd2;
            S_IMM2: begin
                regWriteDataSelect = 2'd2;
                regWrite           = 1'b1;
            end
            S_ALU_R3: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd1;
                aluop4  = opcode[3:0];
            end
            S_ALU_RI3: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd3;
                aluop4  = opcode[3:0];
            end
            S_ALU4: begin
                regWriteDataSelect = 2'd1;
                regWrite           = 1'b1;
            end
            S_BR3: begin
                pcWriteCond = 1'b1;
                aluSrcA     = 1'b1;
                aluSrcB     = 2'd1;
                aluop4      = {1'b1, opcode[2:0]};
            end
            S_MEM3: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd3;
            end
            S_ST4: memRead  = 1'b0;
            S_LD5: regWrite = 1'b1;
            S_J3: begin
                pcWrite = 1'b1;
                pcSrc   = 2'd1;
            end
            default: ;
        endcase
    end

    assign aluOP          = ALUOP_W'(aluop4);
    assign regTrackSelect = (opcode[5:3] == 3'b100) ||
                            (opcode[5:2] == 4'b1011);
    assign state          = state_q;
    assign halted         = halted_q;
    assign error          = error_q;
    assign err_cause      = cause_q;

`ifdef MCU_PERF_COUNT_EN
    logic [31:0] retired_q;
    logic [31:0] stall_q;
    logic        frozen;
    logic        mem_wait;

    assign frozen   = (state_q == S_HALT) || (state_q == S_ERROR);
    assign mem_wait = is_mem && !mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else if (!frozen) begin
            if (state_q != S_IF && state_d == S_IF && retired_q != '1)
                retired_q <= retired_q + 32'd1;
            if (mem_wait && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign instr_retired = retired_q;
    assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit.
// Walks ALU, store-with-wait, timeout, illegal opcode and HALT paths.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [3:0] state;
    logic       pcWrite, pcWriteCond, memGetData, memRead;
    logic       irWrite, regWrite, aluSrcA, regTrackSelect;
    logic [1:0] regWriteDataSelect, aluSrcB, pcSrc;
    logic [3:0] aluOP;
    logic       halted, error;
    logic [1:0] err_cause;
`ifdef MCU_PERF_COUNT_EN
    logic [31:0] instr_retired, stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control_unit #(
        .ALUOP_W(4), .MEM_TIMEOUT(15), .TO_W(4)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .state(state), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
        .memGetData(memGetData), .memRead(memRead), .irWrite(irWrite),
        .regWrite(regWrite), .aluSrcA(aluSrcA),
        .regTrackSelect(regTrackSelect),
        .regWriteDataSelect(regWriteDataSelect), .aluSrcB(aluSrcB),
        .pcSrc(pcSrc), .aluOP(aluOP), .halted(halted), .error(error),
        .err_cause(err_cause)
`ifdef MCU_PERF_COUNT_EN
        , .instr_retired(instr_retired), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000010;
        mem_ready = 1'b1;
        repeat (2) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pcWrite", 32'(pcWrite), 32'd1);
        chk("rst_irWrite", 32'(irWrite), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cause", 32'(err_cause), 32'd0);
        reset = 1'b0;

        // ALU R-type 000010
        tick();
        chk("alu_rf", 32'(state), 32'd1);
        chk("alu_rf_srcb", 32'(aluSrcB), 32'd2);
        tick();
        chk("alu_r3", 32'(state), 32'd3);
        chk("alu_r3_op", 32'(aluOP), 32'd2);
        chk("alu_r3_srca", 32'(aluSrcA), 32'd1);
        tick();
        chk("alu4", 32'(state), 32'd5);
        chk("alu4_rw", 32'(regWrite), 32'd1);
        chk("alu4_rwds", 32'(regWriteDataSelect), 32'd1);
        tick();
        chk("alu_back_if", 32'(state), 32'd0);

        // Store 101100 with 3 wait cycles in ST4
        opcode = 6'b101100;
        tick();
        #1;
        chk("st_rf_track", 32'(regTrackSelect), 32'd1);
        tick();
        chk("st_mem3", 32'(state), 32'd7);
        chk("st_mem3_srcb", 32'(aluSrcB), 32'd3);
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("st4_wait_state", 32'(state), 32'd9);
            chk("st4_wait_mr", 32'(memRead), 32'd0);
            chk("st4_wait_track", 32'(regTrackSelect), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("st4_last_state", 32'(state), 32'd9);
        chk("st4_last_mr", 32'(memRead), 32'd0);
        tick();
        chk("st_back_if", 32'(state), 32'd0);
        chk("st_if_mr", 32'(memRead), 32'd1);

        // Branch 100101 -> aluOP = 1101
        opcode = 6'b100101;
        tick();
        tick();
        chk("br3_state", 32'(state), 32'd6);
        chk("br3_op", 32'(aluOP), 32'd13);
        chk("br3_pwc", 32'(pcWriteCond), 32'd1);
        tick();

        // Jump 110000
        opcode = 6'b110000;
        tick();
        tick();
        chk("j3_state", 32'(state), 32'd11);
        chk("j3_pcw", 32'(pcWrite), 32'd1);
        chk("j3_pcsrc", 32'(pcSrc), 32'd1);
        tick();

        // IF timeout: 15 waiting cycles -> ERROR
        opcode    = 6'b000010;
        mem_ready = 1'b0;
        repeat (14) tick();
        chk("to_still_if", 32'(state), 32'd0);
        chk("to_if_pcw", 32'(pcWrite), 32'd0);
        chk("to_if_irw", 32'(irWrite), 32'd0);
        tick();
        chk("to_state", 32'(state), 32'd13);
        chk("to_error", 32'(error), 32'd1);
        chk("to_cause", 32'(err_cause), 32'd2);
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("to_sticky_state", 32'(state), 32'd13);
        chk("to_sticky_err", 32'(error), 32'd1);
        do_reset();
        chk("to_rst_state", 32'(state), 32'd0);
        chk("to_rst_err", 32'(error), 32'd0);
        chk("to_rst_cause", 32'(err_cause), 32'd0);

        // Ready on the 15th cycle is a success
        mem_ready = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1;
        tick();
        chk("to_edge_state", 32'(state), 32'd1);
        chk("to_edge_err", 32'(error), 32'd0);
        do_reset();

        // Illegal opcode
        opcode = 6'b111010;
        tick();
        tick();
        chk("ill_state", 32'(state), 32'd13);
        chk("ill_error", 32'(error), 32'd1);
        chk("ill_cause", 32'(err_cause), 32'd1);
        chk("ill_rw", 32'(regWrite), 32'd0);
        do_reset();

        // HALT
        opcode = 6'b111111;
        tick();
        tick();
        tick();
        chk("halt_state", 32'(state), 32'd12);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_err", 32'(error), 32'd0);
        chk("halt_we", 32'({pcWrite, pcWriteCond, irWrite, regWrite}),
            32'd0);
        do_reset();
        chk("halt_rst", 32'(halted), 32'd0);

`ifdef MCU_PERF_COUNT_EN
        opcode = 6'b000010;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            repeat (2) tick();
            mem_ready = 1'b1;
            repeat (4) tick();
        end
        chk("perf_state", 32'(state), 32'd0);
        chk("perf_retired", instr_retired, 32'd3);
        chk("perf_stall", stall_cycles, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
